// File: rtl/uart_echo_checker.sv
// Sends a run of incrementing 8N1 bytes, compares each echo against what was sent, and reports errors.
// tx starts 2 cycles after the start pulse; a byte is sent only after the previous echo or its timeout.
module uart_echo_checker #(
  parameter int CLK_FREQ     = 42_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] num_bytes,
  input  logic [7:0]  seed,
  input  logic        rx,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [7:0]  last_rx
);

  localparam int DIV    = CLK_FREQ / BAUD;
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int BW     = $clog2(DIV);
  localparam int TW     = $clog2(TO_CYC);
  localparam logic [BW-1:0] DIV_LAST  = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ECHO, CHECK, FINISH} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  state_t    state_q, state_d;
  rx_state_t rx_st_q, rx_st_d;

  logic          start_q, start_d;
  logic [15:0]   num_stg_q, num_stg_d;
  logic [7:0]    seed_stg_q, seed_stg_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [7:0]    cur_byte_q, cur_byte_d;
  logic [15:0]   err_q, err_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] baud_cnt_q, baud_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;

  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [BW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shreg_q, rx_shreg_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    last_rx_q, last_rx_d;

  logic        baud_end, last_byte, mismatch;
  logic [15:0] err_inc;

  assign baud_end  = (baud_cnt_q == DIV_LAST);
  assign last_byte = (remaining_q == 16'd1);
  assign mismatch  = (rx_byte_q != cur_byte_q) || rx_ferr_q;
  assign err_inc   = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rx_st_q     <= RX_IDLE;
      start_q     <= 1'b0;
      num_stg_q   <= '0;
      seed_stg_q  <= '0;
      remaining_q <= '0;
      cur_byte_q  <= '0;
      err_q       <= '0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
      to_cnt_q    <= '0;
      baud_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '1;
      tx_q        <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_cnt_q    <= '0;
      rx_bit_q    <= '0;
      rx_shreg_q  <= '0;
      rx_byte_q   <= '0;
      rx_ferr_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      last_rx_q   <= '0;
    end else begin
      state_q     <= state_d;
      rx_st_q     <= rx_st_d;
      start_q     <= start_d;
      num_stg_q   <= num_stg_d;
      seed_stg_q  <= seed_stg_d;
      remaining_q <= remaining_d;
      cur_byte_q  <= cur_byte_d;
      err_q       <= err_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      to_cnt_q    <= to_cnt_d;
      baud_cnt_q  <= baud_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      tx_q        <= tx_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shreg_q  <= rx_shreg_d;
      rx_byte_q   <= rx_byte_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_valid_q  <= rx_valid_d;
      last_rx_q   <= last_rx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_q) state_d = (num_stg_q == 16'd0) ? FINISH : SEND;
      SEND:      if (baud_end && bit_cnt_q == 4'd9) state_d = WAIT_ECHO;
      WAIT_ECHO: begin
        if (rx_valid_q) state_d = CHECK;
        else if (to_cnt_q == TO_LAST) state_d = last_byte ? FINISH : SEND;
      end
      CHECK:     state_d = last_byte ? FINISH : SEND;
      FINISH:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    rx_st_d = rx_st_q;
    case (rx_st_q)
      RX_IDLE:  if (rx_prev_q && !rx_sync_q) rx_st_d = RX_START;
      RX_START: if (rx_cnt_q == HALF_LAST) rx_st_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt_q == DIV_LAST && rx_bit_q == 3'd7) rx_st_d = RX_STOP;
      RX_STOP:  if (rx_cnt_q == DIV_LAST) rx_st_d = RX_IDLE;
      default:  rx_st_d = RX_IDLE;
    endcase
  end

  always_comb begin
    // The start request is staged one cycle so num_bytes/seed are captured with it.
    start_d     = start && (state_q == IDLE) && !start_q;
    num_stg_d   = start_d ? num_bytes : num_stg_q;
    seed_stg_d  = start_d ? seed : seed_stg_q;
    remaining_d = remaining_q;
    cur_byte_d  = cur_byte_q;
    err_d       = err_q;
    pass_d      = pass_q;
    done_d      = 1'b0;
    to_cnt_d    = to_cnt_q;
    baud_cnt_d  = baud_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;

    case (state_q)
      IDLE: if (start_q) begin
        remaining_d = num_stg_q;
        cur_byte_d  = seed_stg_q;
        err_d       = '0;
        pass_d      = 1'b0;
      end
      SEND: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = bit_cnt_q + 4'd1;
          shreg_d    = {1'b1, shreg_q[9:1]};
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      WAIT_ECHO: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (!rx_valid_q && to_cnt_q == TO_LAST) begin
          err_d       = err_inc;
          cur_byte_d  = cur_byte_q + 8'd1;
          remaining_d = remaining_q - 16'd1;
        end
      end
      CHECK: begin
        if (mismatch) err_d = err_inc;
        cur_byte_d  = cur_byte_q + 8'd1;
        remaining_d = remaining_q - 16'd1;
      end
      FINISH: begin
        done_d = 1'b1;
        pass_d = (err_q == 16'd0);
      end
      default: ;
    endcase

    if (state_q == SEND && state_d == WAIT_ECHO) to_cnt_d = '0;
    if (state_d == SEND && state_q != SEND) begin
      shreg_d    = {1'b1, cur_byte_d, 1'b0};
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end
    tx_d = (state_d == SEND) ? shreg_d[0] : 1'b1;

    rx_meta_d  = rx;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shreg_d = rx_shreg_q;
    rx_byte_d  = rx_byte_q;
    rx_ferr_d  = rx_ferr_q;
    rx_valid_d = rx_valid_q;
    last_rx_d  = last_rx_q;

    case (rx_st_q)
      RX_IDLE:  rx_cnt_d = '0;
      RX_START: begin
        rx_cnt_d = (rx_cnt_q == HALF_LAST) ? '0 : rx_cnt_q + 1'b1;
        rx_bit_d = '0;
      end
      RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = rx_bit_q + 3'd1;
          rx_shreg_d = {rx_sync_q, rx_shreg_q[7:1]};
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_byte_d  = rx_shreg_q;
          last_rx_d  = rx_shreg_q;
          rx_ferr_d  = !rx_sync_q;
          rx_valid_d = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase

    // Anything held when a new frame starts belongs to an earlier byte.
    if (state_d == SEND && state_q != SEND) rx_valid_d = 1'b0;
  end

  assign tx        = tx_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign last_rx   = last_rx_q;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Directed bench for uart_echo_checker at DIV=10: tx looped to rx through a corruptible echo path.
module tb_uart_echo_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_bytes = '0;
  logic [7:0]  seed = '0;
  logic        rx, tx, busy, done, pass;
  logic [15:0] err_count;
  logic [7:0]  last_rx;

  logic rx_hold = 1'b0;
  logic cor_active = 1'b0;
  logic cor_en = 1'b0;
  int   cor_frame = 0, cor_lo = 0, cor_hi = 0;

  int checks = 0, failures = 0;
  int done_cnt = 0;
  int mon_t = 0;
  logic [7:0] sent_q[$];
  int         start_t_q[$];
  int base, dc;

  assign rx = rx_hold ? 1'b1 : (tx ^ cor_active);

  always #5 clk = ~clk;

  uart_echo_checker #(
    .CLK_FREQ(1_000_000),
    .BAUD(100_000),
    .TIMEOUT_BITS(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_bytes(num_bytes), .seed(seed),
    .rx(rx), .tx(tx), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .last_rx(last_rx)
  );

  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  // Decodes every tx frame at bit centres and drives the echo corruption window.
  initial begin : tx_mon
    int f, t0;
    logic [7:0] d;
    d = '0;
    forever begin
      @(negedge clk);
      mon_t++;
      if (rst_n && tx == 1'b0) begin
        f  = sent_q.size();
        t0 = mon_t;
        for (int k = 1; k <= 99; k++) begin
          @(negedge clk);
          mon_t++;
          if (k >= 15 && k <= 85 && (k % 10) == 5) d = {tx, d[7:1]};
          cor_active = cor_en && (f == cor_frame) && (k >= cor_lo) && (k < cor_hi);
        end
        cor_active = 1'b0;
        sent_q.push_back(d);
        start_t_q.push_back(t0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [15:0] nb, input logic [7:0] sd);
    start = 1'b1;
    num_bytes = nb;
    seed = sd;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy_at_done"}, 32'(busy), 0);
  endtask

  task automatic check_frames(input int b, input int n, input logic [7:0] sd, input int gap);
    logic [7:0] e;
    chk("frame_count", 32'(sent_q.size() - b), 32'(n));
    if (sent_q.size() >= b + n) begin
      for (int i = 0; i < n; i++) begin
        e = sd + 8'(i);
        chk("frame_byte", 32'(sent_q[b + i]), 32'(e));
        if (i > 0) chk("frame_gap", 32'(start_t_q[b + i] - start_t_q[b + i - 1]), 32'(gap));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_last_rx", 32'(last_rx), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Clean loopback, 4 bytes from 0x41
    base = sent_q.size(); dc = done_cnt;
    do_start(16'd4, 8'h41);
    chk("t1_busy_edge_n", 32'(busy), 0);
    @(negedge clk);
    chk("t1_busy_edge_n1", 32'(busy), 1);
    chk("t1_tx_start_bit", 32'(tx), 0);
    wait_done(700, "t1");
    chk("t1_pass", 32'(pass), 1);
    chk("t1_err", 32'(err_count), 0);
    chk("t1_last_rx", 32'(last_rx), 32'h44);
    repeat (3) @(negedge clk);
    chk("t1_done_pulses", 32'(done_cnt - dc), 1);
    check_frames(base, 4, 8'h41, 102);

    // No echo: every byte times out after 32 bit times
    rx_hold = 1'b1;
    base = sent_q.size();
    do_start(16'd3, 8'h30);
    wait_done(1600, "t2");
    chk("t2_err", 32'(err_count), 3);
    chk("t2_pass", 32'(pass), 0);
    chk("t2_last_rx", 32'(last_rx), 32'h44);
    repeat (3) @(negedge clk);
    check_frames(base, 3, 8'h30, 420);
    rx_hold = 1'b0;
    repeat (5) @(negedge clk);

    // Bit 0 of the second echo flipped
    base = sent_q.size();
    cor_frame = base + 1; cor_lo = 10; cor_hi = 20; cor_en = 1'b1;
    do_start(16'd5, 8'h10);
    wait_done(900, "t3");
    chk("t3_err", 32'(err_count), 1);
    chk("t3_pass", 32'(pass), 0);
    chk("t3_last_rx", 32'(last_rx), 32'h14);
    repeat (3) @(negedge clk);
    check_frames(base, 5, 8'h10, 102);

    // Stop bit of the first echo driven low, data intact
    base = sent_q.size();
    cor_frame = base; cor_lo = 90; cor_hi = 98;
    do_start(16'd3, 8'h20);
    wait_done(600, "t4");
    chk("t4_err", 32'(err_count), 1);
    chk("t4_pass", 32'(pass), 0);
    chk("t4_last_rx", 32'(last_rx), 32'h22);
    cor_en = 1'b0;
    repeat (3) @(negedge clk);

    // Byte value wraps 0xFF -> 0x00
    base = sent_q.size();
    do_start(16'd2, 8'hFF);
    wait_done(400, "t5");
    chk("t5_pass", 32'(pass), 1);
    chk("t5_err", 32'(err_count), 0);
    chk("t5_last_rx", 32'(last_rx), 32'h00);
    repeat (3) @(negedge clk);
    check_frames(base, 2, 8'hFF, 102);

    // Zero-length run: done two edges after start, no frame
    base = sent_q.size();
    do_start(16'd0, 8'h99);
    chk("z_done_n", 32'(done), 0);
    @(negedge clk);
    chk("z_busy_n1", 32'(busy), 1);
    chk("z_done_n1", 32'(done), 0);
    chk("z_tx_n1", 32'(tx), 1);
    @(negedge clk);
    chk("z_done_n2", 32'(done), 1);
    chk("z_busy_n2", 32'(busy), 0);
    chk("z_pass_n2", 32'(pass), 1);
    repeat (20) @(negedge clk);
    chk("z_tx_idle", 32'(tx), 1);
    chk("z_no_frame", 32'(sent_q.size() - base), 0);

    // Asynchronous reset in the middle of a data bit
    do_start(16'd3, 8'h00);
    repeat (35) @(negedge clk);
    chk("r_tx_before", 32'(tx), 0);
    chk("r_busy_before", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("r_tx_async", 32'(tx), 1);
    chk("r_busy_async", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("r_pass_cleared", 32'(pass), 0);
    repeat (100) @(negedge clk);

    // Second start while busy must not disturb the run
    base = sent_q.size(); dc = done_cnt;
    do_start(16'd3, 8'h60);
    repeat (20) @(negedge clk);
    chk("r_busy_run", 32'(busy), 1);
    do_start(16'd0, 8'h00);
    wait_done(600, "t6");
    chk("t6_pass", 32'(pass), 1);
    chk("t6_err", 32'(err_count), 0);
    chk("t6_last_rx", 32'(last_rx), 32'h62);
    repeat (40) @(negedge clk);
    chk("t6_done_pulses", 32'(done_cnt - dc), 1);
    chk("t6_idle_after", 32'(busy), 0);
    check_frames(base, 3, 8'h60, 102);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
